// File: rtl/rom_rd_arbiter_pkg.sv
// Shared definitions for the dual-port ROM read arbiter.
// Packed buses (req_addr, rsp_data): requester i occupies bits [i*W +: W], W = slice width.
package rom_rd_arbiter_pkg;

    localparam int DEF_ROM_LATENCY = 2;
    localparam int MAX_IDW         = 3;   // enough for up to 8 requesters

    typedef struct packed {
        logic               vld;
        logic [MAX_IDW-1:0] id;
    } tag_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/rom_rd_arbiter_rr_dual_grant.sv
// Round-robin picker: first two requesters with req set, scanning upward from ptr.
module rr_dual_grant
    import rom_rd_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    input  logic             hold,
    output logic [IDW-1:0]   grant_a,
    output logic             grant_a_vld,
    output logic [IDW-1:0]   grant_b,
    output logic             grant_b_vld
);

    always_comb begin
        grant_a     = '0;
        grant_a_vld = 1'b0;
        grant_b     = '0;
        grant_b_vld = 1'b0;
        if (!hold) begin
            // k is scan distance from ptr; i matches the rotated index so req is only indexed by constants
            for (int k = 0; k < N_REQ; k++) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (i == (int'(ptr) + k) % N_REQ && req[i]) begin
                        if (!grant_a_vld) begin
                            grant_a_vld = 1'b1;
                            grant_a     = IDW'(i);
                        end else if (!grant_b_vld) begin
                            grant_b_vld = 1'b1;
                            grant_b     = IDW'(i);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rom_rd_arbiter.sv
// Arbitrates N_REQ read requesters onto the two read ports of an external ROM
// and routes returning data back to the requester by tag.
module rom_rd_arbiter
    import rom_rd_arbiter_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int MXADRB      = 12,
    parameter int MXDATB      = 9,
    parameter int ROM_LATENCY = DEF_ROM_LATENCY
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*MXADRB-1:0]   req_addr,
    output logic [N_REQ-1:0]          req_ready,
    output logic [MXADRB-1:0]         rom_addra,
    output logic [MXADRB-1:0]         rom_addrb,
    input  logic [MXDATB-1:0]         rom_douta,
    input  logic [MXDATB-1:0]         rom_doutb,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [N_REQ*MXDATB-1:0]   rsp_data,
    output logic                      busy
);

    localparam int IDW  = clog2(N_REQ);
    localparam int CNTW = clog2(2*(ROM_LATENCY+2)+1);
    localparam int L    = ROM_LATENCY;

    logic [IDW-1:0]    rr_ptr, ga, gb, last_gnt;
    logic              ga_vld, gb_vld;
    logic [MXADRB-1:0] addr_a_sel, addr_b_sel;
    logic [N_REQ-1:0]  hit_a, hit_b;
    logic [CNTW-1:0]   inflight, n_acc, n_rsp;
    tag_t              tag_a [L+1];
    tag_t              tag_b [L+1];

    // Reset also masks grants so nothing can be accepted while rst is high.
    rr_dual_grant #(.N_REQ(N_REQ), .IDW(IDW)) u_grant (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .hold        (hold | rst),
        .grant_a     (ga),
        .grant_a_vld (ga_vld),
        .grant_b     (gb),
        .grant_b_vld (gb_vld)
    );

    always_comb begin
        req_ready  = '0;
        addr_a_sel = '0;
        addr_b_sel = '0;
        hit_a      = '0;
        hit_b      = '0;
        n_rsp      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ga_vld && ga == IDW'(i)) begin
                req_ready[i] = 1'b1;
                addr_a_sel   = req_addr[i*MXADRB +: MXADRB];
            end
            if (gb_vld && gb == IDW'(i)) begin
                req_ready[i] = 1'b1;
                addr_b_sel   = req_addr[i*MXADRB +: MXADRB];
            end
            hit_a[i] = tag_a[L].vld && tag_a[L].id == MAX_IDW'(i);
            hit_b[i] = tag_b[L].vld && tag_b[L].id == MAX_IDW'(i);
            n_rsp    = n_rsp + CNTW'(rsp_valid[i]);
        end
    end

    assign n_acc    = CNTW'(ga_vld) + CNTW'(gb_vld);
    assign last_gnt = gb_vld ? gb : ga;
    assign busy     = (inflight != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            rom_addra <= '0;
            rom_addrb <= '0;
            inflight  <= '0;
        end else begin
            if (ga_vld)
                rr_ptr <= (last_gnt == IDW'(N_REQ-1)) ? '0 : last_gnt + IDW'(1);
            if (ga_vld) rom_addra <= addr_a_sel;
            if (gb_vld) rom_addrb <= addr_b_sel;
            inflight <= inflight + n_acc - n_rsp;
        end
    end

    // Tag stage L lines up with the ROM data word for that port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= L; k++) begin
                tag_a[k] <= '0;
                tag_b[k] <= '0;
            end
        end else begin
            tag_a[0] <= {ga_vld, MAX_IDW'(ga)};
            tag_b[0] <= {gb_vld, MAX_IDW'(gb)};
            for (int k = 1; k <= L; k++) begin
                tag_a[k] <= tag_a[k-1];
                tag_b[k] <= tag_b[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                rsp_valid[i] <= hit_a[i] | hit_b[i];
                if (hit_a[i])
                    rsp_data[i*MXDATB +: MXDATB] <= rom_douta;
                else if (hit_b[i])
                    rsp_data[i*MXDATB +: MXDATB] <= rom_doutb;
            end
        end
    end

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Directed bench for rom_rd_arbiter with a 2-cycle synchronous ROM model (data = addr ^ 0x0A5).
module tb_rom_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [47:0] req_addr = '0;
    logic [3:0]  req_ready;
    logic [11:0] rom_addra, rom_addrb;
    logic [8:0]  rom_douta = '0, rom_doutb = '0;
    logic [8:0]  pa = '0, pb = '0;
    logic [3:0]  rsp_valid;
    logic [35:0] rsp_data;
    logic        busy;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    rom_rd_arbiter #(.N_REQ(4), .MXADRB(12), .MXDATB(9), .ROM_LATENCY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rom_addra (rom_addra),
        .rom_addrb (rom_addrb),
        .rom_douta (rom_douta),
        .rom_doutb (rom_doutb),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    function automatic logic [8:0] rom_f(input logic [11:0] a);
        return a[8:0] ^ 9'h0A5;
    endfunction

    always @(posedge clk) begin
        pa        <= rom_f(rom_addra);
        pb        <= rom_f(rom_addrb);
        rom_douta <= pa;
        rom_doutb <= pb;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_addr(input int i, input logic [11:0] a);
        req_addr[i*12 +: 12] = a;
    endtask

    function automatic logic [8:0] slice(input int i);
        return rsp_data[i*9 +: 9];
    endfunction

    int p0, p2, p3, first2, last2, maxcnt;

    initial begin
        // reset state
        step(); step(); settle();
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_addra", rom_addra, 12'h000);
        chk("rst_addrb", rom_addrb, 12'h000);
        chk("rst_rspv", rsp_valid, 4'b0000);
        chk("rst_busy", busy, 1'b0);

        // four requesters, two cycles
        step(); rst = 1'b0; req_valid = 4'b1111;
        set_addr(0, 12'h010); set_addr(1, 12'h020); set_addr(2, 12'h030); set_addr(3, 12'h040);
        settle();
        chk("t1_ready0", req_ready, 4'b0011);
        step(); settle();
        chk("t1_addra1", rom_addra, 12'h010);
        chk("t1_addrb1", rom_addrb, 12'h020);
        chk("t1_ready1", req_ready, 4'b1100);
        chk("t1_busy1", busy, 1'b1);
        step(); req_valid = 4'b0000; settle();
        chk("t1_addra2", rom_addra, 12'h030);
        chk("t1_addrb2", rom_addrb, 12'h040);
        chk("t1_ready2", req_ready, 4'b0000);
        step(); settle();
        chk("t1_rspv3", rsp_valid, 4'b0000);
        step(); settle();
        chk("t1_rspv4", rsp_valid, 4'b0011);
        chk("t1_d0", slice(0), 9'h0B5);
        chk("t1_d1", slice(1), 9'h085);
        step(); settle();
        chk("t1_rspv5", rsp_valid, 4'b1100);
        chk("t1_d2", slice(2), 9'h095);
        chk("t1_d3", slice(3), 9'h0E5);
        chk("t1_d0hold", slice(0), 9'h0B5);
        chk("t1_busy5", busy, 1'b1);
        step(); settle();
        chk("t1_rspv6", rsp_valid, 4'b0000);
        chk("t1_busy6", busy, 1'b0);

        // single requester 2, five cycles, port A only
        p2 = 0; first2 = -1; last2 = -1;
        set_addr(2, 12'h123);
        for (int k = 0; k < 12; k++) begin
            step();
            req_valid = (k < 5) ? 4'b0100 : 4'b0000;
            settle();
            if (k < 5) chk("t2_ready", req_ready, 4'b0100);
            if (k == 5) chk("t2_addra", rom_addra, 12'h123);
            chk("t2_addrb", rom_addrb, 12'h040);
            if (rsp_valid[2]) begin
                p2++;
                if (first2 < 0) first2 = k;
                last2 = k;
            end
        end
        chk("t2_pulses", p2, 5);
        chk("t2_first", first2, 4);
        chk("t2_last", last2, 8);
        chk("t2_d2", slice(2), 9'h186);

        // hold blocks grants but not an in-flight read
        step(); req_valid = 4'b0001; set_addr(0, 12'h055); settle();
        chk("t3_ready0", req_ready, 4'b0001);
        for (int k = 1; k < 8; k++) begin
            step(); hold = 1'b1; req_valid = 4'b1111; settle();
            chk("t3_hold_ready", req_ready, 4'b0000);
            if (k == 4) begin
                chk("t3_rspv", rsp_valid, 4'b0001);
                chk("t3_d0", slice(0), 9'h0F0);
                chk("t3_busy_hi", busy, 1'b1);
            end
            if (k == 5) begin
                chk("t3_busy_lo", busy, 1'b0);
                chk("t3_rspv_lo", rsp_valid, 4'b0000);
            end
        end

        // reset with reads in flight
        step(); hold = 1'b0; req_valid = 4'b0011;
        set_addr(0, 12'h111); set_addr(1, 12'h222); settle();
        chk("t4_ready", req_ready, 4'b0011);
        step(); req_valid = 4'b0000; settle();
        step(); rst = 1'b1; req_valid = 4'b1111; settle();
        chk("t4_ready_rst", req_ready, 4'b0000);
        chk("t4_addra", rom_addra, 12'h000);
        chk("t4_addrb", rom_addrb, 12'h000);
        chk("t4_rspv", rsp_valid, 4'b0000);
        chk("t4_data", rsp_data, 36'h0);
        chk("t4_busy", busy, 1'b0);
        step(); settle();
        chk("t4_ready_rst2", req_ready, 4'b0000);
        step(); rst = 1'b0; req_valid = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("t4_no_rsp", rsp_valid, 4'b0000);
            chk("t4_no_busy", busy, 1'b0);
            step();
        end

        // requesters 0 and 3 for eight cycles
        p0 = 0; p3 = 0; maxcnt = 0;
        set_addr(0, 12'h0C0); set_addr(3, 12'h3F0);
        for (int k = 0; k < 14; k++) begin
            req_valid = (k < 8) ? 4'b1001 : 4'b0000;
            settle();
            if (k < 8) chk("t5_ready", req_ready, 4'b1001);
            if (k == 1) begin
                chk("t5_addra", rom_addra, 12'h0C0);
                chk("t5_addrb", rom_addrb, 12'h3F0);
            end
            if (rsp_valid[0]) p0++;
            if (rsp_valid[3]) p3++;
            if (int'(dut.inflight) > maxcnt) maxcnt = int'(dut.inflight);
            step();
        end
        chk("t5_p0", p0, 8);
        chk("t5_p3", p3, 8);
        chk("t5_maxcnt", maxcnt, 8);
        chk("t5_d0", slice(0), 9'h065);
        chk("t5_d3", slice(3), 9'h155);

        // three requesters: pointer rotation
        req_valid = 4'b1110; settle();
        chk("t6_ready0", req_ready, 4'b0110);
        step(); settle();
        chk("t6_ready1", req_ready, 4'b1010);
        step(); settle();
        chk("t6_ready2", req_ready, 4'b1100);
        step(); req_valid = 4'b0000;
        for (int k = 0; k < 6; k++) step();
        settle();
        chk("t6_busy_end", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/rom_rd_arbiter.md
ROM_RD_ARBITER -- requirements
Module: rom_rd_arbiter

Interface
REQ-001 The module SHALL have parameter N_REQ, default 4, number of read requesters (2..8).
REQ-002 The module SHALL have parameter MXADRB, default 12, ROM address width.
REQ-003 The module SHALL have parameter MXDATB, default 9, ROM data width.
REQ-004 The module SHALL have parameter ROM_LATENCY, default 2, clock cycles from ROM address sample to valid ROM data.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have port hold, input, 1 bit: when high, no new grants are issued.
REQ-008 The module SHALL have port req_valid, input, N_REQ bits: per-requester read request.
REQ-009 The module SHALL have port req_addr, input, N_REQ*MXADRB bits: packed request addresses, requester i at slice i.
REQ-010 The module SHALL have port req_ready, output, N_REQ bits: combinational grant; a request is accepted when req_valid[i] and req_ready[i] are both high on a rising edge.
REQ-011 The module SHALL have ports rom_addra and rom_addrb, output, MXADRB bits each: registered addresses to the two ROM read ports.
REQ-012 The module SHALL have ports rom_douta and rom_doutb, input, MXDATB bits each: ROM read data.
REQ-013 The module SHALL have port rsp_valid, output, N_REQ bits: per-requester response strobe.
REQ-014 The module SHALL have port rsp_data, output, N_REQ*MXDATB bits: packed response data; slice i is valid when rsp_valid[i] is high.
REQ-015 The module SHALL have port busy, output, 1 bit: high while any accepted read has no response yet.

Function
REQ-016 Each cycle, the module SHALL grant at most two requesters: port A to the first requester with req_valid set, scanning round-robin from rr_ptr; port B to the next such requester after it.
REQ-017 With hold high, the module SHALL drive req_ready to all zeros.
REQ-018 A requester SHALL receive at most one grant per cycle.
REQ-019 After any grant, rr_ptr SHALL move to (index of last granted requester + 1) mod N_REQ; with no grant, rr_ptr SHALL hold.
REQ-020 On an accept in cycle t, the granted address SHALL appear on rom_addrX in cycle t+1.
REQ-021 A port with no grant SHALL keep its previous rom_addrX value.
REQ-022 Each port SHALL carry a tag pipeline of {valid, requester id} of depth ROM_LATENCY+1, aligned with that port's ROM data.
REQ-023 Response timing: an accept in cycle t SHALL produce rsp_valid[id] high for exactly one cycle, t+ROM_LATENCY+2, with the ROM data registered into the slice for that id.
REQ-024 Port A and port B responses in the same cycle go to distinct requesters (guaranteed by REQ-018), and both SHALL be delivered in that cycle.
REQ-025 rsp_data slices SHALL hold their last value when not strobed.
REQ-026 An in-flight counter SHALL be incremented by the number of accepts and decremented by the number of responses in the same cycle; simultaneous accepts and responses SHALL net correctly.
REQ-027 The in-flight counter width SHALL be clog2(2*(ROM_LATENCY+2)+1); busy = (count != 0).
REQ-028 Asserting hold SHALL NOT cancel in-flight reads; their responses SHALL still be delivered.
REQ-029 A requester that keeps req_valid high SHALL be granted at most N_REQ-1 cycles after it first requests (round-robin fairness).

Reset
REQ-030 While rst is high, the module SHALL asynchronously clear rr_ptr, rom_addra, rom_addrb, all tag pipelines, the in-flight counter, rsp_valid, and rsp_data to 0.
REQ-031 While rst is high, req_ready SHALL be 0.
REQ-032 Reads in flight when reset asserts SHALL be discarded, producing no response after reset releases.
REQ-033 The first grant after reset release SHALL start the scan at requester 0.

Structure
REQ-034 Function clog2 and a default ROM_LATENCY constant SHALL live in the shared package; the packed-slice index convention SHALL be documented there.
REQ-035 The round-robin dual-grant logic SHALL be a sub-module rr_dual_grant (inputs: req vector, ptr, hold; outputs: grant_a and grant_b indices with valid flags).
REQ-036 The ROM itself SHALL be external to this module.

Verification
REQ-037 After reset, req_valid=4'b1111 with addresses 0x010/0x020/0x030/0x040 held 2 cycles: the bench SHALL see grants {0,1}, then {2,3}, and rsp_valid bits 0,1 four cycles after the first accept with ROM data for addresses 0x010 and 0x020.
REQ-038 Only requester 2 requests, continuously, for 5 cycles: the bench SHALL see it granted every cycle on port A, five consecutive rsp_valid[2] pulses, and rom_addrb unchanged.
REQ-039 hold=1 with all requests high: req_ready SHALL be 0; with a prior read in flight, its response SHALL still arrive, and busy SHALL fall one cycle after it.
REQ-040 rst asserted two cycles after accepts to requesters 0 and 1: every output SHALL be 0 immediately, and no rsp_valid SHALL occur after release.
REQ-041 With requesters 0 and 3 held requesting for 8 cycles, grants SHALL alternate fairly (pair {3,0} order under rr_ptr wrap); the in-flight count SHALL never exceed 2*(ROM_LATENCY+2)=8.
